file_register_param: RTL and testbench
======================================

// Module: file_register_param
// PURPOSE
//  Parametrised multi-port register file: next generation of the 32x32 file register.
//  Two registered read ports with write-to-read bypass; one write port; optional hardwired-zero entry 0.
//  Adds a per-entry busy scoreboard (reserve/release) for hazard checks.
//  Adds a sequential bulk-clear engine. Sits between decode (reads, reserves) and writeback (writes).
// PARAMETERS
//  WIDTH     32  data bits per entry
//  DEPTH     32  number of entries (>=2; need not be a power of 2)
//  ADDR_W    $clog2(DEPTH)  address width (derived; do not override)
//  ZERO_REG  1   1: entry 0 reads 0, is never written, never busy
//  BYPASS    1   1: same-cycle write data forwarded to a read of the same address
// PORTS
//  clk          in   1       clock, all state updates on rising edge
//  rst          in   1       asynchronous, active-high reset
//  we           in   1       write enable
//  write_addr   in   ADDR_W  write entry
//  write_data   in   WIDTH   write data
//  re           in   1       read enable (both read ports)
//  read0_addr   in   ADDR_W  read port 0 entry
//  read1_addr   in   ADDR_W  read port 1 entry
//  read0_data   out  WIDTH   registered read port 0 data
//  read1_data   out  WIDTH   registered read port 1 data
//  rsv          in   1       reserve: mark rsv_addr busy (pending producer)
//  rsv_addr     in   ADDR_W  entry to reserve
//  busy0        out  1       busy bit of read0_addr (combinational from scoreboard)
//  busy1        out  1       busy bit of read1_addr (combinational from scoreboard)
//  clear_req    in   1       request bulk clear of all entries
//  ready        out  1       1 = IDLE, accepting we/re/rsv
// BEHAVIOUR
//  Reset (async, rst=1): all entries 0; read0_data=read1_data=0; busy vector 0; FSM IDLE; ready=1.
//  Reset mid-clear aborts the sweep immediately with the same result.
//  FSM: IDLE -> CLEAR on clear_req in IDLE (ptr<=0).
//  CLEAR: each cycle writes 0 to entry ptr and clears busy[ptr]; ptr++; from ptr==DEPTH-1 -> IDLE.
//  Clear takes exactly DEPTH cycles; ready=0 throughout.
//  In CLEAR: we, re, rsv and clear_req are ignored; read0/1_data hold.
//  Write (IDLE, we=1): entry[write_addr]<=write_data and busy[write_addr]<=0 at edge.
//  Write to entry 0 is discarded when ZERO_REG=1.
//  Read (IDLE, re=1): readN_data<=entry[readN_addr] at edge; latency 1 cycle; re=0 holds outputs.
//  Bypass: BYPASS=1 and we=1 with write_addr==readN_addr (non-zero entry when ZERO_REG) -> readN_data<=write_data.
//  BYPASS=0 -> old value.
//  Both read ports may address the same entry; both return identical data.
//  Reserve (IDLE, rsv=1): busy[rsv_addr]<=1; rsv to entry 0 ignored when ZERO_REG=1.
//  Same-edge we and rsv to the same address: data written AND busy ends 1 (reserve wins: new producer).
//  busyN = busy[readN_addr], no bypass of same-cycle we/rsv; entry 0 reports 0 when ZERO_REG=1.
//  Address >= DEPTH (non-power-of-2 DEPTH): write/reserve ignored; read returns 0; busy reports 0.
//  clear_req and we/rsv in the same IDLE cycle: the write/reserve is performed, then CLEAR starts next cycle and wipes it.
// TESTING
//  1. rst pulse mid-cycle (no clk edge) -> read0_data=read1_data=0, ready=1, busy0=busy1=0 immediately.
//  2. we=1 addr 5 data 0xDEADBEEF; next cycle re=1 read0=5, read1=5
//     -> both read 0xDEADBEEF one cycle later.
//  3. Same-edge we addr 7 data 0x1234 and re read0=7: BYPASS=1 -> 0x1234; BYPASS=0 -> previous 0x0.
//  4. ZERO_REG=1: we addr 0 data 0xFFFFFFFF, rsv addr 0, then read0=0 -> data 0, busy0=0.
//  5. rsv addr 3 -> busy0=1 (read0=3) next cycle.
//     Write addr 3 -> busy0=0; same-edge we+rsv addr 3 -> busy0 stays 1.
//  6. DEPTH=24: fill entries, clear_req -> ready=0 for exactly 24 cycles, we/re ignored.
//     All entries then read 0 and busy=0; rst at cycle 10 of clear -> ready=1 at once.

Source files
------------

// File: rtl/file_register_param.sv
// Parametrised register file: two registered read ports with optional write bypass,
// one write port, per-entry busy scoreboard and a sequential bulk-clear sweep.
module file_register_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [WIDTH-1:0]  write_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] read0_addr,
  input  logic [ADDR_W-1:0] read1_addr,
  output logic [WIDTH-1:0]  read0_data,
  output logic [WIDTH-1:0]  read1_data,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy0,
  output logic              busy1,
  input  logic              clear_req,
  output logic              ready
);

  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W-1:0] ptr;
  logic              write_ok, rsv_ok;
  logic [WIDTH-1:0]  read0_next, read1_next;

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign ready    = (state_q == IDLE);
  assign write_ok = ready && we && writable(write_addr);
  assign rsv_ok   = ready && rsv && writable(rsv_addr);
  assign busy0    = writable(read0_addr) && busy[read0_addr];
  assign busy1    = writable(read1_addr) && busy[read1_addr];

  always_comb begin
    read0_next = '0;
    read1_next = '0;
    if ((BYPASS != 0) && write_ok && (write_addr == read0_addr))
      read0_next = write_data;
    else if (in_range(read0_addr))
      read0_next = mem[read0_addr];
    if ((BYPASS != 0) && write_ok && (write_addr == read1_addr))
      read1_next = write_data;
    else if (in_range(read1_addr))
      read1_next = mem[read1_addr];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (ptr == LAST_PTR) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A reserve issued on the same edge as a write to that entry leaves it busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      busy       <= '0;
      read0_data <= '0;
      read1_data <= '0;
      ptr        <= '0;
    end else if (state_q == CLEAR) begin
      mem[ptr]  <= '0;
      busy[ptr] <= 1'b0;
      ptr       <= ptr + ADDR_W'(1);
    end else begin
      if (write_ok) begin
        mem[write_addr]  <= write_data;
        busy[write_addr] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
      if (re) begin
        read0_data <= read0_next;
        read1_data <= read1_next;
      end
      if (clear_req) ptr <= '0;
    end
  end

endmodule

// File: tb/tb_file_register_param.sv
// Bench for file_register_param: two DEPTH=24 instances (zero-reg+bypass, and neither)
// driven in lockstep and checked against an array-based reference model.
module tb_file_register_param;

  localparam int DEPTH = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, re, rsv, clear_req;
  logic [4:0]  write_addr, read0_addr, read1_addr, rsv_addr;
  logic [31:0] write_data;

  logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
  logic        busy0_a, busy1_a, busy0_b, busy1_b, ready_a, ready_b;

  logic [31:0] rd0 [2];
  logic [31:0] rd1 [2];
  logic        bz0 [2];
  logic        bz1 [2];
  logic        rdy [2];

  assign rd0[0] = rd0_a;   assign rd0[1] = rd0_b;
  assign rd1[0] = rd1_a;   assign rd1[1] = rd1_b;
  assign bz0[0] = busy0_a; assign bz0[1] = busy0_b;
  assign bz1[0] = busy1_a; assign bz1[1] = busy1_b;
  assign rdy[0] = ready_a; assign rdy[1] = ready_b;

  file_register_param #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .re(re), .read0_addr(read0_addr), .read1_addr(read1_addr),
    .read0_data(rd0_a), .read1_data(rd1_a), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy0(busy0_a), .busy1(busy1_a), .clear_req(clear_req), .ready(ready_a)
  );

  file_register_param #(.WIDTH(32), .DEPTH(DEPTH), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .re(re), .read0_addr(read0_addr), .read1_addr(read1_addr),
    .read0_data(rd0_b), .read1_data(rd1_b), .rsv(rsv), .rsv_addr(rsv_addr),
    .busy0(busy0_b), .busy1(busy1_b), .clear_req(clear_req), .ready(ready_b)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 = zero-reg + bypass instance, index 1 = plain instance.
  logic [31:0] m_mem [2][32];
  bit          m_busy [2][32];
  logic [31:0] m_rd0 [2];
  logic [31:0] m_rd1 [2];
  int          clear_left;

  int          total = 0;
  int          bad = 0;
  logic [66:0] obs, expv;

  function automatic logic exp_busy(input int k, input logic [4:0] a);
    if (int'(a) >= DEPTH) return 1'b0;
    if (k == 0 && a == 5'd0) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[k][i]  = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_rd0[k] = 32'h0;
      m_rd1[k] = 32'h0;
    end
    clear_left = 0;
  endtask

  task automatic idle_inputs();
    we = 1'b0; re = 1'b0; rsv = 1'b0; clear_req = 1'b0;
    write_addr = 5'd0; read0_addr = 5'd0; read1_addr = 5'd0; rsv_addr = 5'd0;
    write_data = 32'h0;
  endtask

  task automatic random_inputs();
    we         = 1'($urandom_range(0, 1));
    re         = 1'($urandom_range(0, 1));
    rsv        = 1'($urandom_range(0, 1));
    clear_req  = ($urandom_range(0, 63) == 0);
    write_addr = 5'($urandom_range(0, 31));
    read0_addr = 5'($urandom_range(0, 31));
    read1_addr = 5'($urandom_range(0, 31));
    rsv_addr   = 5'($urandom_range(0, 31));
    write_data = $urandom;
  endtask

  // Advance the model by one clock using the inputs currently driven, then clock the DUTs.
  task automatic tick();
    logic wok, rok;
    bit   zr;
    if (clear_left > 0) begin
      clear_left--;
    end else begin
      for (int k = 0; k < 2; k++) begin
        zr  = (k == 0);
        wok = we && (int'(write_addr) < DEPTH) && !(zr && write_addr == 5'd0);
        rok = rsv && (int'(rsv_addr) < DEPTH) && !(zr && rsv_addr == 5'd0);
        if (re) begin
          m_rd0[k] = (zr && wok && write_addr == read0_addr) ? write_data :
                     (int'(read0_addr) < DEPTH ? m_mem[k][read0_addr] : 32'h0);
          m_rd1[k] = (zr && wok && write_addr == read1_addr) ? write_data :
                     (int'(read1_addr) < DEPTH ? m_mem[k][read1_addr] : 32'h0);
        end
        if (wok) begin
          m_mem[k][write_addr]  = write_data;
          m_busy[k][write_addr] = 1'b0;
        end
        if (rok) m_busy[k][rsv_addr] = 1'b1;
      end
      if (clear_req) begin
        clear_left = DEPTH;
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < 32; i++) begin
            m_mem[k][i]  = 32'h0;
            m_busy[k][i] = 1'b0;
          end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #2;
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL reset_initial dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b1; write_addr = 5'd9; write_data = 32'hCAFE0009;
    rsv = 1'b1; rsv_addr = 5'd9;
    re = 1'b1; read0_addr = 5'd9; read1_addr = 5'd9;
    tick();
    idle_inputs();
    read0_addr = 5'd9; read1_addr = 5'd9;
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL pre_reset_state dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL reset_async dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    idle_inputs();
    we = 1'b1; write_addr = 5'd5; write_data = 32'hDEADBEEF;
    tick();
    idle_inputs();
    re = 1'b1; read0_addr = 5'd5; read1_addr = 5'd5;
    tick();
    for (int k = 0; k < 2; k++) begin
      total++;
      if (rd0[k] !== 32'hDEADBEEF || rd1[k] !== 32'hDEADBEEF) begin
        bad++;
        $display("[TB] FAIL write_read dut%0d got=%h/%h exp=deadbeef", k, rd0[k], rd1[k]);
      end
    end
  endtask

  task automatic test_bypass();
    idle_inputs();
    we = 1'b1; write_addr = 5'd7; write_data = 32'h00001234;
    re = 1'b1; read0_addr = 5'd7; read1_addr = 5'd5;
    tick();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL bypass dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
    rsv = 1'b1; rsv_addr = 5'd0;
    tick();
    idle_inputs();
    re = 1'b1; read0_addr = 5'd0; read1_addr = 5'd0;
    tick();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL zero_reg dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_busy();
    idle_inputs();
    rsv = 1'b1; rsv_addr = 5'd3; read0_addr = 5'd3; read1_addr = 5'd4;
    tick();
    for (int step = 0; step < 3; step++) begin
      for (int k = 0; k < 2; k++) begin
        total++;
        if (bz0[k] !== exp_busy(k, read0_addr) || bz1[k] !== exp_busy(k, read1_addr)) begin
          bad++;
          $display("[TB] FAIL busy_step%0d dut%0d got=%b%b exp=%b%b", step, k, bz0[k], bz1[k],
                   exp_busy(k, read0_addr), exp_busy(k, read1_addr));
        end
      end
      idle_inputs();
      read0_addr = 5'd3; read1_addr = 5'd4;
      we = 1'b1; write_addr = 5'd3; write_data = $urandom;
      if (step == 1) begin
        rsv = 1'b1; rsv_addr = 5'd3;
      end
      if (step < 2) tick();
    end
  endtask

  task automatic test_out_of_range();
    idle_inputs();
    we = 1'b1; write_addr = 5'd26; write_data = 32'h5A5A5A5A;
    rsv = 1'b1; rsv_addr = 5'd30;
    tick();
    idle_inputs();
    re = 1'b1; read0_addr = 5'd26; read1_addr = 5'd30;
    tick();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL out_of_range dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      random_inputs();
      tick();
      for (int k = 0; k < 2; k++) begin
        total++;
        if (clear_left == 0) begin
          obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
          expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
        end else begin
          obs  = {2'b00, rd0[k], rd1[k], rdy[k]};
          expv = {2'b00, m_rd0[k], m_rd1[k], 1'b0};
        end
        if (obs !== expv) begin
          bad++;
          $display("[TB] FAIL random cyc%0d dut%0d got=%h exp=%h", n, k, obs, expv);
        end
      end
    end
  endtask

  task automatic test_clear();
    int cnt;
    idle_inputs();
    for (int i = 0; i < 30 && clear_left > 0; i++) tick();
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; write_addr = 5'(a); write_data = $urandom | 32'h1;
      rsv = 1'b1; rsv_addr = 5'((a + 5) % DEPTH);
      tick();
    end
    idle_inputs();
    clear_req = 1'b1;
    we = 1'b1; write_addr = 5'd2; write_data = 32'h77777777;
    rsv = 1'b1; rsv_addr = 5'd4;
    tick();
    cnt = 0;
    while (rdy[0] === 1'b0 && cnt < 40) begin
      cnt++;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (rd0[k] !== m_rd0[k] || rd1[k] !== m_rd1[k] || rdy[k] !== 1'b0) begin
          bad++;
          $display("[TB] FAIL clear_hold dut%0d got=%h/%h/%b exp=%h/%h/0", k, rd0[k], rd1[k],
                   rdy[k], m_rd0[k], m_rd1[k]);
        end
      end
      random_inputs();
      tick();
    end
    total++;
    if (cnt != DEPTH) begin
      bad++;
      $display("[TB] FAIL clear_length got=%0d exp=%0d", cnt, DEPTH);
    end
    for (int a = 0; a < DEPTH; a += 2) begin
      idle_inputs();
      re = 1'b1; read0_addr = 5'(a); read1_addr = 5'(a + 1);
      tick();
      for (int k = 0; k < 2; k++) begin
        obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
        expv = {32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
        total++;
        if (obs !== expv) begin
          bad++;
          $display("[TB] FAIL clear_result a=%0d dut%0d got=%h exp=%h", a, k, obs, expv);
        end
      end
    end
  endtask

  task automatic test_clear_abort();
    idle_inputs();
    we = 1'b1; write_addr = 5'd6; write_data = 32'h0BADF00D;
    tick();
    idle_inputs();
    clear_req = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {32'h0, 32'h0, 1'b0, 1'b0, 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL clear_abort dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    we = 1'b1; write_addr = 5'd6; write_data = 32'h13572468;
    tick();
    idle_inputs();
    re = 1'b1; read0_addr = 5'd6; read1_addr = 5'd11;
    tick();
    for (int k = 0; k < 2; k++) begin
      obs  = {rd0[k], rd1[k], bz0[k], bz1[k], rdy[k]};
      expv = {m_rd0[k], m_rd1[k], exp_busy(k, read0_addr), exp_busy(k, read1_addr), 1'b1};
      total++;
      if (obs !== expv) begin
        bad++;
        $display("[TB] FAIL after_abort dut%0d got=%h exp=%h", k, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_busy();
    test_out_of_range();
    test_random();
    test_clear();
    test_clear_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
